// File: rtl/div_ctrl.sv
// Radix-2 restoring DIV/DIVU unit; optional DIV_EARLY_OUT_EN finishes |a|<|b| cases in the accept cycle.
// Latency: start at cycle 0 -> done_o at cycle WIDTH+1 (cycle 1 on an early-out).
// Backpressure: stall_o holds the pipe from accept through the last iteration; annul_i aborts.
module div_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   opa_i,
   input  logic [WIDTH-1:0]   opb_i,
   input  logic               annul_i,
   output logic               busy_o,
   output logic               stall_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] result_o
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t             state;
   logic [WIDTH-1:0]   dvd;        // dividend shifts out MSB-first, quotient bits shift in
   logic [WIDTH-1:0]   dvs;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   rawA;
   logic [CNT_W-1:0]   cnt;
   logic               negQ;
   logic               negR;
   logic               divZero;
   logic [2*WIDTH-1:0] resultReg;

   logic [WIDTH-1:0]   absA;
   logic [WIDTH-1:0]   absB;
   logic               accept;
   logic               earlyOut;
   logic [WIDTH:0]     remShift;
   logic [WIDTH:0]     remDiff;
   logic               qBit;
   logic [WIDTH-1:0]   remNext;
   logic [WIDTH-1:0]   quoFix;
   logic [WIDTH-1:0]   remFix;

   always_comb begin
      absA     = (signed_i & opa_i[WIDTH-1]) ? -opa_i : opa_i;
      absB     = (signed_i & opb_i[WIDTH-1]) ? -opb_i : opb_i;
      accept   = (state == IDLE) & start_i & ~annul_i;
`ifdef DIV_EARLY_OUT_EN
      earlyOut = (opb_i != '0) && (absA < absB);
`else
      earlyOut = 1'b0;
`endif
      remShift = {rem, dvd[WIDTH-1]};
      remDiff  = remShift - {1'b0, dvs};
      qBit     = ~remDiff[WIDTH];
      remNext  = qBit ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
      // Divide-by-zero bypasses sign fixup: all-ones quotient, raw dividend as remainder.
      quoFix   = divZero ? '1   : (negQ ? -dvd : dvd);
      remFix   = divZero ? rawA : (negR ? -rem : rem);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         dvd       <= '0;
         dvs       <= '0;
         rem       <= '0;
         rawA      <= '0;
         cnt       <= '0;
         negQ      <= 1'b0;
         negR      <= 1'b0;
         divZero   <= 1'b0;
         resultReg <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  dvs     <= absB;
                  rawA    <= opa_i;
                  cnt     <= '0;
                  negQ    <= signed_i & (opa_i[WIDTH-1] ^ opb_i[WIDTH-1]);
                  negR    <= signed_i & opa_i[WIDTH-1];
                  divZero <= (opb_i == '0);
                  if (earlyOut) begin
                     dvd   <= '0;
                     rem   <= absA;
                     state <= DONE;
                  end else begin
                     dvd   <= absA;
                     rem   <= '0;
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (annul_i) begin
                  state <= IDLE;
               end else begin
                  rem <= remNext;
                  dvd <= {dvd[WIDTH-2:0], qBit};
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST_CNT) state <= DONE;
               end
            end
            DONE: begin
               if (!annul_i) resultReg <= {remFix, quoFix};
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The fixed-up result is shown during DONE so hi/lo is written in the same cycle as done_o.
   assign busy_o   = (state != IDLE);
   assign stall_o  = rst & (accept | (state == BUSY));
   assign done_o   = rst & (state == DONE) & ~annul_i;
   assign result_o = done_o ? {remFix, quoFix} : resultReg;

endmodule
